// File: rtl/sirv_tl_pkg.sv
// Shared TileLink types and constants for the sirv peripheral path.
// Used by the repeater and the fragmenter that follows it.
package sirv_tl_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    REPEAT = 1'b1
  } rpt_state_e;

  localparam logic [2:0] TL_PUT_FULL    = 3'd0;
  localparam logic [2:0] TL_PUT_PARTIAL = 3'd1;
  localparam logic [2:0] TL_GET         = 3'd4;

  localparam int DEF_ADDR_W = 30;
  localparam int DEF_SRC_W  = 2;

endpackage

// File: rtl/sirv_repeater_addr_step.sv
// Combinational address + (1 << size), modulo 2^ADDR_W.
// A size that shifts past the address width contributes no step.
module sirv_repeater_addr_step
  import sirv_tl_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [2:0]        size,
  output logic [ADDR_W-1:0] next_addr
);

  logic [ADDR_W-1:0] step;

  always_comb begin
    step = '0;
    if (int'(size) < ADDR_W)
      step = ADDR_W'(1) << size;
  end

  assign next_addr = addr + step;

endmodule

// File: rtl/sirv_repeater_burst.sv
// TileLink-A repeater: passes a request through and replays it
// rpt_cnt more times, optionally stepping the address per beat.
module sirv_repeater_burst
  import sirv_tl_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = 8,
  parameter int MASK_W = 1,
  parameter int SRC_W  = DEF_SRC_W,
  parameter int CNT_W  = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [CNT_W-1:0]  rpt_cnt,
  input  logic              addr_inc,
  output logic              full,
  output logic [CNT_W-1:0]  remaining,
  output logic              enq_ready,
  input  logic              enq_valid,
  input  logic [2:0]        enq_bits_opcode,
  input  logic [2:0]        enq_bits_param,
  input  logic [2:0]        enq_bits_size,
  input  logic [SRC_W-1:0]  enq_bits_source,
  input  logic [ADDR_W-1:0] enq_bits_address,
  input  logic [MASK_W-1:0] enq_bits_mask,
  input  logic [DATA_W-1:0] enq_bits_data,
  input  logic              deq_ready,
  output logic              deq_valid,
  output logic [2:0]        deq_bits_opcode,
  output logic [2:0]        deq_bits_param,
  output logic [2:0]        deq_bits_size,
  output logic [SRC_W-1:0]  deq_bits_source,
  output logic [ADDR_W-1:0] deq_bits_address,
  output logic [MASK_W-1:0] deq_bits_mask,
  output logic [DATA_W-1:0] deq_bits_data
);

  rpt_state_e        state;
  logic [CNT_W-1:0]  rem_q;
  logic              inc_q;
  logic [2:0]        opcode_q;
  logic [2:0]        param_q;
  logic [2:0]        size_q;
  logic [SRC_W-1:0]  source_q;
  logic [ADDR_W-1:0] address_q;
  logic [MASK_W-1:0] mask_q;
  logic [DATA_W-1:0] data_q;

  logic              idle;
  logic [ADDR_W-1:0] step_addr;
  logic [ADDR_W-1:0] next_addr;
  logic [2:0]        step_size;

  assign idle      = (state == IDLE);
  assign full      = ~idle;
  assign remaining = rem_q;

  assign enq_ready = idle & deq_ready;
  assign deq_valid = idle ? enq_valid : 1'b1;

  assign deq_bits_opcode  = idle ? enq_bits_opcode  : opcode_q;
  assign deq_bits_param   = idle ? enq_bits_param   : param_q;
  assign deq_bits_size    = idle ? enq_bits_size    : size_q;
  assign deq_bits_source  = idle ? enq_bits_source  : source_q;
  assign deq_bits_address = idle ? enq_bits_address : address_q;
  assign deq_bits_mask    = idle ? enq_bits_mask    : mask_q;
  assign deq_bits_data    = idle ? enq_bits_data    : data_q;

  // One stepper serves both the entry offset and each replay step.
  assign step_addr = idle ? enq_bits_address : address_q;
  assign step_size = idle ? enq_bits_size : size_q;

  sirv_repeater_addr_step #(
    .ADDR_W(ADDR_W)
  ) u_step (
    .addr      (step_addr),
    .size      (step_size),
    .next_addr (next_addr)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      rem_q     <= '0;
      inc_q     <= 1'b0;
      opcode_q  <= '0;
      param_q   <= '0;
      size_q    <= '0;
      source_q  <= '0;
      address_q <= '0;
      mask_q    <= '0;
      data_q    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (enq_valid && deq_ready && rpt_cnt != '0) begin
            state     <= REPEAT;
            rem_q     <= rpt_cnt;
            inc_q     <= addr_inc;
            opcode_q  <= enq_bits_opcode;
            param_q   <= enq_bits_param;
            size_q    <= enq_bits_size;
            source_q  <= enq_bits_source;
            address_q <= addr_inc ? next_addr : enq_bits_address;
            mask_q    <= enq_bits_mask;
            data_q    <= enq_bits_data;
          end
        end
        REPEAT: begin
          if (deq_ready) begin
            assert (rem_q != '0);
            rem_q <= rem_q - 1'b1;
            if (inc_q)
              address_q <= next_addr;
            if (rem_q == CNT_W'(1))
              state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sirv_repeater_burst.sv
// Directed bench for sirv_repeater_burst: pass-through, replay,
// stepping with backpressure, wrap, reset abort and back-to-back.
module tb_sirv_repeater_burst;

  logic        clock;
  logic        reset;
  logic [3:0]  rpt_cnt;
  logic        addr_inc;
  logic        full;
  logic [3:0]  remaining;
  logic        enq_ready;
  logic        enq_valid;
  logic [2:0]  enq_bits_opcode;
  logic [2:0]  enq_bits_param;
  logic [2:0]  enq_bits_size;
  logic [1:0]  enq_bits_source;
  logic [29:0] enq_bits_address;
  logic [0:0]  enq_bits_mask;
  logic [7:0]  enq_bits_data;
  logic        deq_ready;
  logic        deq_valid;
  logic [2:0]  deq_bits_opcode;
  logic [2:0]  deq_bits_param;
  logic [2:0]  deq_bits_size;
  logic [1:0]  deq_bits_source;
  logic [29:0] deq_bits_address;
  logic [0:0]  deq_bits_mask;
  logic [7:0]  deq_bits_data;

  int n_chk;
  int n_fail;
  int beats;
  int accepts;

  sirv_repeater_burst dut (
    .clock            (clock),
    .reset            (reset),
    .rpt_cnt          (rpt_cnt),
    .addr_inc         (addr_inc),
    .full             (full),
    .remaining        (remaining),
    .enq_ready        (enq_ready),
    .enq_valid        (enq_valid),
    .enq_bits_opcode  (enq_bits_opcode),
    .enq_bits_param   (enq_bits_param),
    .enq_bits_size    (enq_bits_size),
    .enq_bits_source  (enq_bits_source),
    .enq_bits_address (enq_bits_address),
    .enq_bits_mask    (enq_bits_mask),
    .enq_bits_data    (enq_bits_data),
    .deq_ready        (deq_ready),
    .deq_valid        (deq_valid),
    .deq_bits_opcode  (deq_bits_opcode),
    .deq_bits_param   (deq_bits_param),
    .deq_bits_size    (deq_bits_size),
    .deq_bits_source  (deq_bits_source),
    .deq_bits_address (deq_bits_address),
    .deq_bits_mask    (deq_bits_mask),
    .deq_bits_data    (deq_bits_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic req(input logic [2:0] op, input logic [29:0] addr,
                     input logic [2:0] size, input logic [7:0] data,
                     input logic [3:0] cnt, input logic inc);
    enq_valid        = 1'b1;
    enq_bits_opcode  = op;
    enq_bits_param   = 3'd0;
    enq_bits_size    = size;
    enq_bits_source  = 2'd1;
    enq_bits_address = addr;
    enq_bits_mask    = 1'b1;
    enq_bits_data    = data;
    rpt_cnt          = cnt;
    addr_inc         = inc;
  endtask

  logic [29:0] inc_addr [4];
  logic [3:0]  inc_rem  [4];
  logic        inc_rdy  [4];
  logic        b2b_rdy  [3];
  logic [29:0] b2b_addr [3];
  logic        b2b_full [3];

  initial begin
    n_chk = 0;
    n_fail = 0;
    reset = 1'b1;
    deq_ready = 1'b0;
    req(3'd0, 30'd0, 3'd0, 8'd0, 4'd0, 1'b0);
    enq_valid = 1'b0;
    #1;
    chk("rst_full", full, 0);
    chk("rst_rem", remaining, 0);
    chk("rst_deq_valid", deq_valid, 0);
    @(negedge clock);
    reset = 1'b0;

    // Pass-through
    @(negedge clock);
    req(3'd4, 30'h100, 3'd2, 8'h3C, 4'd0, 1'b0);
    deq_ready = 1'b1;
    #1;
    chk("pt_valid", deq_valid, 1);
    chk("pt_addr", deq_bits_address, 30'h100);
    chk("pt_op", deq_bits_opcode, 3'd4);
    chk("pt_size", deq_bits_size, 3'd2);
    chk("pt_src", deq_bits_source, 2'd1);
    chk("pt_data", deq_bits_data, 8'h3C);
    chk("pt_enq_ready", enq_ready, 1);
    chk("pt_full", full, 0);
    @(posedge clock); #1;
    chk("pt_full_after", full, 0);
    chk("pt_rem_after", remaining, 0);

    // Fixed repeat x3
    @(negedge clock);
    req(3'd0, 30'h40, 3'd0, 8'hA5, 4'd3, 1'b0);
    #1;
    chk("fx_b1_addr", deq_bits_address, 30'h40);
    chk("fx_b1_rdy", enq_ready, 1);
    @(posedge clock); #1;
    chk("fx_b1_full", full, 1);
    chk("fx_b1_rem", remaining, 3);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      enq_valid = 1'b0;
      enq_bits_address = 30'h77;
      enq_bits_data = 8'h00;
      #1;
      chk("fx_valid", deq_valid, 1);
      chk("fx_addr", deq_bits_address, 30'h40);
      chk("fx_data", deq_bits_data, 8'hA5);
      chk("fx_op", deq_bits_opcode, 3'd0);
      chk("fx_enq_rdy", enq_ready, 0);
      @(posedge clock); #1;
      chk("fx_rem", remaining, 4'(2 - i));
      chk("fx_full", full, (i < 2));
    end

    // Increment with backpressure
    inc_rdy  = '{1'b0, 1'b0, 1'b1, 1'b1};
    inc_addr = '{30'h1004, 30'h1004, 30'h1004, 30'h1008};
    inc_rem  = '{4'd2, 4'd2, 4'd1, 4'd0};
    @(negedge clock);
    req(3'd4, 30'h1000, 3'd2, 8'h11, 4'd2, 1'b1);
    deq_ready = 1'b1;
    #1;
    chk("inc_b1_addr", deq_bits_address, 30'h1000);
    @(posedge clock);
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      enq_valid = 1'b0;
      deq_ready = inc_rdy[i];
      #1;
      chk("inc_valid", deq_valid, 1);
      chk("inc_addr", deq_bits_address, inc_addr[i]);
      @(posedge clock); #1;
      chk("inc_rem", remaining, inc_rem[i]);
    end
    chk("inc_full_end", full, 0);

    // Address wrap
    @(negedge clock);
    deq_ready = 1'b1;
    req(3'd4, 30'h3FFFFFFC, 3'd2, 8'h00, 4'd1, 1'b1);
    #1;
    chk("wrap_b1", deq_bits_address, 30'h3FFFFFFC);
    @(negedge clock);
    enq_valid = 1'b0;
    #1;
    chk("wrap_b2", deq_bits_address, 30'h0);
    chk("wrap_b2_valid", deq_valid, 1);
    @(posedge clock); #1;
    chk("wrap_full", full, 0);

    // Reset mid-burst
    @(negedge clock);
    req(3'd4, 30'h200, 3'd0, 8'h00, 4'd15, 1'b1);
    @(posedge clock);
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      enq_valid = 1'b0;
      @(posedge clock);
    end
    #1;
    chk("rm_rem_b5", remaining, 11);
    chk("rm_full_b5", full, 1);
    @(negedge clock);
    req(3'd4, 30'h300, 3'd0, 8'h00, 4'd0, 1'b0);
    reset = 1'b1;
    #1;
    chk("rm_full", full, 0);
    chk("rm_rem", remaining, 0);
    chk("rm_deq_valid", deq_valid, 1);
    chk("rm_deq_addr", deq_bits_address, 30'h300);
    #2;
    reset = 1'b0;
    @(negedge clock);
    req(3'd4, 30'h304, 3'd2, 8'h5A, 4'd0, 1'b0);
    #1;
    chk("rm_next_addr", deq_bits_address, 30'h304);
    chk("rm_next_data", deq_bits_data, 8'h5A);
    chk("rm_next_rdy", enq_ready, 1);
    @(posedge clock); #1;
    chk("rm_next_full", full, 0);

    // Back-to-back with enq_valid held
    b2b_rdy  = '{1'b1, 1'b0, 1'b1};
    b2b_addr = '{30'h500, 30'h500, 30'h600};
    b2b_full = '{1'b0, 1'b1, 1'b0};
    beats = 0;
    accepts = 0;
    @(negedge clock);
    req(3'd4, 30'h500, 3'd0, 8'h00, 4'd1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      #1;
      if (deq_valid && deq_ready) beats++;
      if (enq_valid && enq_ready) accepts++;
      if (i < 3) begin
        chk("b2b_enq_rdy", enq_ready, b2b_rdy[i]);
        chk("b2b_addr", deq_bits_address, b2b_addr[i]);
        chk("b2b_full", full, b2b_full[i]);
      end
      @(negedge clock);
      if (i == 0) req(3'd4, 30'h600, 3'd0, 8'h00, 4'd0, 1'b0);
      if (i == 2) enq_valid = 1'b0;
    end
    chk("b2b_beats", beats, 3);
    chk("b2b_accepts", accepts, 2);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sirv_repeater_burst.md
Name: sirv_repeater_burst

Overview:
Parametrised successor of the TileLink-A single-shot repeater. It captures one A-channel request and replays it rpt_cnt additional times, optionally stepping the address by the beat size on each replay. With rpt_cnt = 0 it is a zero-latency pass-through.
It sits between a TL master (or fragmenter) and a narrow peripheral bus. It expands one logical request into a counted beat sequence without the upstream holding valid.

Parameters:
ADDR_W, 30, address width
DATA_W, 8, data width
MASK_W, 1, byte-mask width (DATA_W/8, minimum 1)
SRC_W, 2, source-id width
CNT_W, 4, repeat-count width (max extra repeats 2^CNT_W-1)

Ports:
clock  in  1  clock
reset  in  1  asynchronous, active-high reset
rpt_cnt  in  CNT_W  extra replays requested; sampled only on enq fire
addr_inc  in  1  1 = step address by 2^size per replay; sampled on enq fire
full  out  1  replay in progress (saved request drives deq)
remaining  out  CNT_W  replays still to be issued after the current deq beat
enq_ready / enq_valid  out/in  1  upstream handshake
enq_bits_opcode, _param, _size  in  3 each
enq_bits_source  in  SRC_W
enq_bits_address  in  ADDR_W
enq_bits_mask  in  MASK_W
enq_bits_data  in  DATA_W
deq_ready / deq_valid  in/out  1  downstream handshake
deq_bits_*  out  same widths as enq_bits_*

Behaviour:
- Reset: state IDLE, full=0, remaining=0, all saved fields and the step flag 0. Asynchronous assert; leaves reset on the first clock edge after deassert.
- States: IDLE, REPEAT. full = (state==REPEAT).
- IDLE, combinational pass-through, 0-cycle latency:
  - deq_valid = enq_valid; deq_bits = enq_bits; enq_ready = deq_ready.
  - enq fire = enq_valid & enq_ready.
  - enq fire with rpt_cnt=0: stay IDLE, nothing saved.
  - enq fire with rpt_cnt≠0: save all bits, save addr_inc, remaining <= rpt_cnt, go to REPEAT.
  - Saved address on entry = enq address + (addr_inc ? 2^size : 0).
- REPEAT:
  - enq_ready=0; deq_valid=1; deq_bits = saved fields, address = saved address.
  - On deq fire (deq_ready & deq_valid): remaining <= remaining-1. If the step flag is set, saved address <= saved address + 2^size.
  - When remaining==1 at the fire, go to IDLE; remaining becomes 0 the same edge.
- deq_valid is never retracted in REPEAT. Saved bits are stable except for the address step on fire.
- Address arithmetic is modulo 2^ADDR_W: wrap is silent, no error. Step = 1<<size computed at ADDR_W width. If size ≥ ADDR_W, the step is 0.
- remaining never underflows. A deq fire in REPEAT with remaining==0 is unreachable; assert it in simulation.
- The enq port is not inspected in REPEAT. A new request waits until the cycle after the return to IDLE, so back-to-back bursts carry one idle-pass cycle of enq_ready=deq_ready.
- Reset mid-burst aborts the burst: state IDLE, remaining 0. No partial-burst indication.
- Legacy single-repeat usage is rpt_cnt=1, addr_inc=0. This gives exactly one replay of the unchanged request.

Decomposition:
- Shared package sirv_tl_pkg holds:
  - State enum type (IDLE, REPEAT).
  - TL opcode constants (PutFull=0, PutPartial=1, Get=4).
  - Default width localparams (ADDR_W=30, SRC_W=2).
- One optional sub-module, sirv_repeater_addr_step: a combinational address + (1<<size) with width guard. Reused by the future fragmenter.
- Everything else stays in the top module.

Test Plan:
- Pass-through: rpt_cnt=0, enq Get addr 0x100 size 2, deq_ready=1 → deq shows identical bits the same cycle; full stays 0; enq_ready=1.
- Fixed repeat: rpt_cnt=3, addr_inc=0, PutFull addr 0x40 data 0xA5 → 4 deq beats all at addr 0x40 data 0xA5. remaining reads 3,2,1,0 across the beats; full drops after beat 4; enq_ready=0 for beats 2–4.
- Increment with backpressure: rpt_cnt=2, addr_inc=1, size 2, addr 0x1000, deq_ready toggling 1,0,0,1,1 → addresses 0x1000, 0x1004, 0x1008. Each address is held stable while deq_ready=0.
- Wrap: ADDR_W=30, addr 0x3FFFFFFC, size 2, rpt_cnt=1, addr_inc=1 → beats at 0x3FFFFFFC then 0x00000000.
- Reset mid-burst: rpt_cnt=15, async reset after beat 5 → full=0, remaining=0, deq_valid follows enq_valid immediately. The next request passes through unchanged.
- Back-to-back: rpt_cnt=1 then rpt_cnt=0 with enq_valid held → second request is accepted only in the cycle after full falls; no beat is lost or duplicated (beat count 3 total).
